// File: rtl/ram_slot_scheduler.sv
// ram_slot_scheduler: shares the system RAM between video fetch and the processor.
// Slots alternate VID/CPU on ram_en; an optional DMA port (RAM_DMA_EN) steals CPU slots.
//
// Ports:
//   clk, RESET (async, active high)
//   ram_en               slot strobe from the timing generator
//   vid_addr/vid_data/vid_valid          video fetch side
//   cpu_addr/cpu_ram_sel/cpu_rnw/cpu_wdata/cpu_rdata/proc_en/cpu_ready
//   dma_req/dma_rnw/dma_addr/dma_wdata/dma_rdata/dma_ack  (live only with RAM_DMA_EN)
//   ram_cs/ram_we/ram_addr/ram_wdata/ram_rdata          synchronous RAM
//
// Macro RAM_DMA_EN: when defined, DMA may take every other CPU read slot.
// When undefined, all CPU slots go to the CPU and the DMA outputs are tied off.

module ram_slot_scheduler #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              ram_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_ram_sel,
  input  logic              cpu_rnw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              proc_en,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    SLOT_VID,
    SLOT_CPU
  } slot_t;

  typedef enum logic [1:0] {
    CAP_NONE,
    CAP_VID,
    CAP_CPU,
    CAP_DMA
  } cap_t;

  slot_t             slot;
  cap_t              cap;
  logic              cap_rd;
  logic [DATA_W-1:0] vid_q;
  logic [DATA_W-1:0] cpu_q;

  logic              dma_win;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_we;
  logic              own_rd;

  assign ram_cs = ram_en;

`ifdef RAM_DMA_EN
  logic              last_dma;
  logic [DATA_W-1:0] dma_q;

  // The cap==DMA term keeps a request that is still
  // high on its ack cycle from being granted again.
  assign dma_win = (slot == SLOT_CPU) & dma_req
                 & cpu_rnw & ~last_dma
                 & (cap != CAP_DMA);

  assign own_addr  = dma_win ? dma_addr : cpu_addr;
  assign own_wdata = dma_win ? dma_wdata : cpu_wdata;
  assign own_we    = dma_win ? ~dma_rnw
                             : ~cpu_rnw & cpu_ram_sel;
  assign own_rd    = dma_win ? dma_rnw
                             : cpu_rnw & cpu_ram_sel;

  assign cpu_ready = ~(ram_en & dma_win);
  assign dma_ack   = (cap == CAP_DMA);
  assign dma_rdata = (cap == CAP_DMA && cap_rd)
                   ? ram_rdata : dma_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      last_dma <= 1'b0;
      dma_q    <= '0;
    end else begin
      if (cap == CAP_DMA && cap_rd)
        dma_q <= ram_rdata;
      if (ram_en && slot == SLOT_CPU)
        last_dma <= dma_win;
    end
  end
`else
  logic unused_dma;

  assign unused_dma = ^{dma_req, dma_rnw,
                        dma_addr, dma_wdata};

  assign dma_win   = 1'b0;
  assign own_addr  = cpu_addr;
  assign own_wdata = cpu_wdata;
  assign own_we    = ~cpu_rnw & cpu_ram_sel;
  assign own_rd    = cpu_rnw & cpu_ram_sel;
  assign cpu_ready = 1'b1;
  assign dma_ack   = 1'b0;
  assign dma_rdata = '0;
`endif

  always_comb begin
    ram_addr  = vid_addr;
    ram_wdata = own_wdata;
    ram_we    = 1'b0;
    if (slot == SLOT_CPU) begin
      ram_addr = own_addr;
      ram_we   = ram_en & own_we;
    end
  end

  // Data outputs bypass the hold register in the capture
  // clk so data and strobe line up one clk after ram_en.
  assign vid_valid = (cap == CAP_VID);
  assign proc_en   = (cap == CAP_CPU);
  assign vid_data  = (cap == CAP_VID) ? ram_rdata : vid_q;
  assign cpu_rdata = (cap == CAP_CPU && cap_rd)
                   ? ram_rdata : cpu_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      slot   <= SLOT_VID;
      cap    <= CAP_NONE;
      cap_rd <= 1'b0;
      vid_q  <= '0;
      cpu_q  <= '0;
    end else begin
      unique case (cap)
        CAP_VID: vid_q <= ram_rdata;
        CAP_CPU: if (cap_rd) cpu_q <= ram_rdata;
        default: ;
      endcase
      if (ram_en) begin
        if (slot == SLOT_VID) begin
          slot   <= SLOT_CPU;
          cap    <= CAP_VID;
          cap_rd <= 1'b1;
        end else begin
          slot   <= SLOT_VID;
          cap    <= dma_win ? CAP_DMA : CAP_CPU;
          cap_rd <= own_rd;
        end
      end else begin
        cap    <= CAP_NONE;
        cap_rd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_slot_scheduler.sv
// tb_ram_slot_scheduler: directed bench for ram_slot_scheduler.
// Models a 32 KiB synchronous RAM; DMA steps run only with RAM_DMA_EN.

module tb_ram_slot_scheduler;

  logic        clk = 1'b0;
  logic        RESET;
  logic        ram_en;
  logic [14:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [14:0] cpu_addr;
  logic        cpu_ram_sel;
  logic        cpu_rnw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        proc_en;
  logic        cpu_ready;
  logic        dma_req;
  logic        dma_rnw;
  logic [14:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        ram_cs;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:32767];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  ram_slot_scheduler #(.ADDR_W(15), .DATA_W(8)) dut (
    .clk(clk), .RESET(RESET), .ram_en(ram_en),
    .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .cpu_addr(cpu_addr),
    .cpu_ram_sel(cpu_ram_sel), .cpu_rnw(cpu_rnw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .proc_en(proc_en), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_rnw(dma_rnw),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_dma;
    logic is_cpu;
    int   cidx;
    int   dma_n;

    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h3000] = 8'hA5;
    mem[15'h0042] = 8'h77;
    ram_rdata   = 8'h00;
    RESET       = 1'b1;
    ram_en      = 1'b0;
    vid_addr    = 15'h3000;
    cpu_addr    = 15'h0000;
    cpu_ram_sel = 1'b0;
    cpu_rnw     = 1'b1;
    cpu_wdata   = 8'h00;
    dma_req     = 1'b0;
    dma_rnw     = 1'b1;
    dma_addr    = 15'h0000;
    dma_wdata   = 8'h00;

    cyc(); cyc();
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_proc_en", proc_en, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    RESET = 1'b0;

    // VID slot at 0x3000
    cyc(); ram_en = 1'b1; #1;
    chk("v0_addr", ram_addr, 15'h3000);
    chk("v0_we", ram_we, 0);
    chk("v0_ready", cpu_ready, 1);
    // CPU write 0x5A -> 0x1234
    cyc(); ram_en = 1'b0; #1;
    chk("v0_valid", vid_valid, 1);
    chk("v0_data", vid_data, 8'hA5);
    chk("v0_proc_en", proc_en, 0);
    cyc(); ram_en = 1'b1;
    cpu_ram_sel = 1'b1; cpu_rnw = 1'b0;
    cpu_addr = 15'h1234; cpu_wdata = 8'h5A; #1;
    chk("cw_we", ram_we, 1);
    chk("cw_addr", ram_addr, 15'h1234);
    chk("cw_wdata", ram_wdata, 8'h5A);
    chk("cw_ready", cpu_ready, 1);
    cyc(); ram_en = 1'b0; #1;
    chk("cw_proc_en", proc_en, 1);
    chk("cw_vid_valid", vid_valid, 0);
    chk("cw_rdata_hold", cpu_rdata, 0);
    chk("cw_we_no_en", ram_we, 0);
    // VID slot reads the freshly written byte
    cyc(); ram_en = 1'b1; vid_addr = 15'h1234; #1;
    chk("v1_proc_en", proc_en, 0);
    cyc(); ram_en = 1'b0; #1;
    chk("v1_valid", vid_valid, 1);
    chk("v1_data", vid_data, 8'h5A);
    // CPU read 0x1234
    cyc(); ram_en = 1'b1; cpu_rnw = 1'b1; #1;
    chk("cr_we", ram_we, 0);
    cyc(); ram_en = 1'b0; #1;
    chk("cr_proc_en", proc_en, 1);
    chk("cr_rdata", cpu_rdata, 8'h5A);
    chk("cr_vid_hold", vid_data, 8'h5A);

    // back-to-back: VID 0x3000 then CPU read 0x0042
    cyc(); ram_en = 1'b1; vid_addr = 15'h3000;
    cpu_addr = 15'h0042; #1;
    chk("bb_vaddr", ram_addr, 15'h3000);
    cyc(); ram_en = 1'b1; #1;
    chk("bb_caddr", ram_addr, 15'h0042);
    chk("bb_vvalid", vid_valid, 1);
    chk("bb_vdata", vid_data, 8'hA5);
    cyc(); ram_en = 1'b0; #1;
    chk("bb_proc_en", proc_en, 1);
    chk("bb_crdata", cpu_rdata, 8'h77);
    chk("bb_vvalid0", vid_valid, 0);
    chk("bb_vdata_hold", vid_data, 8'hA5);

    // CPU slot without RAM select
    cyc(); ram_en = 1'b1; #1;
    cyc(); ram_en = 1'b1; cpu_ram_sel = 1'b0;
    cpu_rnw = 1'b0; cpu_addr = 15'h0050; #1;
    chk("ns_we", ram_we, 0);
    cyc(); ram_en = 1'b0; #1;
    chk("ns_proc_en", proc_en, 1);
    chk("ns_rdata_hold", cpu_rdata, 8'h77);
    chk("ns_mem", mem[15'h0050], 8'h00);

`ifdef RAM_DMA_EN
    // contention: DMA writes 0x0100..0x0103 vs CPU reads
    cpu_ram_sel = 1'b1; cpu_rnw = 1'b1; cpu_addr = 15'h0042;
    dma_req = 1'b1; dma_rnw = 1'b0;
    dma_addr = 15'h0100; dma_wdata = 8'hD0;
    cidx = 0; dma_n = 0;
    for (int s = 0; s < 16; s++) begin
      cyc(); ram_en = 1'b1; #1;
      is_cpu  = (s % 2 == 1);
      exp_dma = is_cpu && (cidx % 2 == 0);
      if (is_cpu) cidx++;
      chk("dc_ready", cpu_ready, !exp_dma);
      chk("dc_we", ram_we, exp_dma);
      cyc(); ram_en = 1'b0; #1;
      chk("dc_ack", dma_ack, exp_dma);
      chk("dc_proc_en", proc_en, is_cpu && !exp_dma);
      chk("dc_ready_idle", cpu_ready, 1);
      if (dma_ack) begin
        dma_n++;
        dma_addr = dma_addr + 15'd1;
        dma_wdata = dma_wdata + 8'd1;
        if (dma_n == 4) dma_req = 1'b0;
      end
    end
    chk("dc_ack_count", dma_n, 4);
    chk("dc_mem0", mem[15'h0100], 8'hD0);
    chk("dc_mem1", mem[15'h0101], 8'hD1);
    chk("dc_mem2", mem[15'h0102], 8'hD2);
    chk("dc_mem3", mem[15'h0103], 8'hD3);

    // DMA read of 0x0101
    cyc(); ram_en = 1'b1; #1;
    cyc(); ram_en = 1'b1; dma_req = 1'b1;
    dma_rnw = 1'b1; dma_addr = 15'h0101; #1;
    chk("dr_ready", cpu_ready, 0);
    chk("dr_addr", ram_addr, 15'h0101);
    cyc(); ram_en = 1'b0; #1;
    chk("dr_ack", dma_ack, 1);
    chk("dr_rdata", dma_rdata, 8'hD1);
    chk("dr_proc_en", proc_en, 0);
    dma_req = 1'b0;

    // DMA blocked by CPU writes
    cyc(); dma_req = 1'b1; dma_rnw = 1'b0;
    dma_addr = 15'h0200; dma_wdata = 8'hEE;
    cpu_rnw = 1'b0; cpu_addr = 15'h0300; cpu_wdata = 8'h33;
    for (int s = 0; s < 2; s++) begin
      cyc(); ram_en = 1'b1; #1;
      cyc(); ram_en = 1'b1; #1;
      chk("bw_ready", cpu_ready, 1);
      chk("bw_we", ram_we, 1);
      chk("bw_addr", ram_addr, 15'h0300);
      cyc(); ram_en = 1'b0; #1;
      chk("bw_ack", dma_ack, 0);
      chk("bw_proc_en", proc_en, 1);
    end
    chk("bw_mem", mem[15'h0300], 8'h33);
    cpu_rnw = 1'b1;
    cyc(); ram_en = 1'b1; #1;
    cyc(); ram_en = 1'b1; #1;
    chk("bw_dma_ready", cpu_ready, 0);
    chk("bw_dma_addr", ram_addr, 15'h0200);
    chk("bw_dma_we", ram_we, 1);
    cyc(); ram_en = 1'b0; #1;
    chk("bw_dma_ack", dma_ack, 1);
    dma_req = 1'b0;
    cyc(); #1;
    chk("bw_dma_mem", mem[15'h0200], 8'hEE);
`else
    // DMA ignored: request never takes a slot
    cpu_ram_sel = 1'b1; cpu_rnw = 1'b1; cpu_addr = 15'h0042;
    dma_req = 1'b1; dma_rnw = 1'b0;
    dma_addr = 15'h0100; dma_wdata = 8'hD0;
    cyc(); ram_en = 1'b1; #1;
    cyc(); ram_en = 1'b1; #1;
    chk("nd_ready", cpu_ready, 1);
    chk("nd_addr", ram_addr, 15'h0042);
    chk("nd_we", ram_we, 0);
    cyc(); ram_en = 1'b0; #1;
    chk("nd_proc_en", proc_en, 1);
    chk("nd_ack", dma_ack, 0);
    chk("nd_rdata", dma_rdata, 0);
    dma_req = 1'b0;
`endif

    // reset in the clk after a CPU-slot ram_en
    cpu_addr = 15'h0042; cpu_rnw = 1'b1; cpu_ram_sel = 1'b1;
    vid_addr = 15'h3000;
    cyc(); ram_en = 1'b1; #1;
    cyc(); ram_en = 1'b1; #1;
    chk("rm_caddr", ram_addr, 15'h0042);
    cyc(); ram_en = 1'b0; RESET = 1'b1; #1;
    chk("rm_proc_en", proc_en, 0);
    chk("rm_ready", cpu_ready, 1);
    chk("rm_rdata", cpu_rdata, 0);
    cyc(); #1;
    chk("rm_proc_en2", proc_en, 0);
    RESET = 1'b0;
    cyc(); ram_en = 1'b1; #1;
    chk("rm_next_vid", ram_addr, 15'h3000);
    cyc(); ram_en = 1'b0; #1;
    chk("rm_vvalid", vid_valid, 1);
    chk("rm_vdata", vid_data, 8'hA5);
    chk("rm_proc_en3", proc_en, 0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_slot_scheduler.md
# ram_slot_scheduler

Sequences the shared 32 KiB system RAM between the video fetch path (CRTC/framestore) and the processor-side bus, and lets an optional DMA requester (SD loader) steal processor slots. RAM slots alternate between video and processor. The block issues the RAM address and write strobe, captures read data, and generates the processor clock enable and READY. It sits between the timing generator's RAM slot strobe and the RAM array.

## Interface
Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system pixel clock.
- RESET  in  1  asynchronous, active-high reset.
- ram_en  in  1  RAM slot strobe, one clk wide; may be asserted on consecutive clks.
- vid_addr  in  ADDR_W  video fetch address, sampled in video slots.
- vid_data  out  DATA_W  last video byte.
- vid_valid  out  1  one-clk pulse when vid_data updates.
- cpu_addr  in  ADDR_W  processor address, with A15 already decoded away.
- cpu_ram_sel  in  1  processor cycle targets RAM.
- cpu_rnw  in  1  processor read (1) / write (0).
- cpu_wdata  in  DATA_W  processor write data.
- cpu_rdata  out  DATA_W  processor read data.
- proc_en  out  1  one-clk processor clock-enable pulse.
- cpu_ready  out  1  processor READY; low while DMA owns the slot.
- dma_req  in  1  DMA request; held until acked.
- dma_rnw  in  1  DMA read / write.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data.
- dma_ack  out  1  one-clk pulse when the DMA access has completed.
- ram_cs  out  1  RAM enable; equal to ram_en.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  synchronous RAM read data, valid one clk after ram_cs.

## Operation
- **slot register:** toggles VID↔CPU on every ram_en. Reset value is VID, so the first ram_en is a video slot.
- **Combinational RAM drive:**
  - VID slot: ram_addr=vid_addr, ram_we=0.
  - CPU slot: ram_addr/ram_we/ram_wdata come from the slot owner.
  - ram_we asserts only when ram_en=1.
- **CPU-slot owner decision, made at ram_en:**
  - DMA owns the slot iff dma_req=1 AND cpu_rnw=1 AND last_dma=0.
  - Otherwise the CPU owns it.
  - last_dma is set when DMA takes a slot and cleared when the CPU takes one. This guarantees the CPU at least every other CPU slot.
  - A CPU write cycle is never preempted.
- **CPU-owned slot:**
  - cpu_ram_sel=0: no RAM access (ram_we=0); proc_en still pulses.
  - CPU write: ram_we = ~cpu_rnw & cpu_ram_sel.
- **cpu_ready:** combinationally low in any CPU slot granted to DMA, high otherwise.
- **Capture register** cap ∈ {NONE, VID, CPU, DMA}, loaded at each ram_en with the slot's consumer. On the following clk:
  - VID: vid_data←ram_rdata, vid_valid=1.
  - CPU: cpu_rdata←ram_rdata if it was a RAM read; proc_en=1.
  - DMA: dma_rdata←ram_rdata if it was a read; dma_ack=1.
- **DMA handshake:** after dma_ack, the requester may reassert dma_req on the next clk. A DMA request present on the ack cycle is not re-granted in the same slot.

## Timing
- **Reset values:** vid_data=0, cpu_rdata=0, dma_rdata=0, vid_valid=0, proc_en=0, dma_ack=0, cpu_ready=1, slot=VID, last_dma=0, cap=NONE.
- **Read latency:** 1 clk from ram_en to capture and strobe.
- **Write latency:** ram_we is in the ram_en clk; proc_en or dma_ack follows 1 clk later.
- **Back-to-back ram_en:** the capture of slot N and the issue of slot N+1 occur in the same clk. Data must not be corrupted.
- **RESET mid-slot:** any pending capture is discarded. No proc_en or dma_ack pulse follows.

## Configuration
- **RAM_DMA_EN defined:** DMA port is functional as above.
- **RAM_DMA_EN undefined:** DMA logic is removed.
  - Every CPU slot goes to the CPU.
  - cpu_ready is tied to 1.
  - dma_ack and dma_rdata are tied to 0; DMA inputs are ignored.

## Test plan
- **Reset, then ram_en every 2 clks, no DMA:** slots alternate VID, CPU, VID, CPU. vid_valid and proc_en each pulse once per 4 clks. cpu_ready stays 1.
- **CPU write then read:** CPU writes 0x5A to 0x1234; a later CPU read of 0x1234 gives cpu_rdata=0x5A one clk after its ram_en.
- **Video fetch:** RAM[0x3000]=0xA5 with vid_addr=0x3000 gives vid_data=0xA5 and vid_valid=1 one clk after the VID-slot ram_en.
- **DMA contention:** dma_req held with DMA writes to 0x0100..0x0103 and cpu_rnw=1.
  - CPU slots alternate DMA, CPU, DMA, CPU…
  - cpu_ready is low only in the DMA-owned slots.
  - Four dma_ack pulses occur; RAM contents are verified afterwards.
- **DMA blocked by write:** dma_req=1 with cpu_rnw=0 and cpu_ram_sel=1. The CPU write completes and dma_ack stays 0 until cpu_rnw returns to 1.
- **Reset mid-slot:** RESET asserted in the clk after a CPU-slot ram_en. proc_en stays 0, cpu_ready=1, and the next slot after release is VID.
